deal_sequencer: RTL
===================

// Module: deal_sequencer
// PURPOSE
//  Multi-cycle deck controller: initialises a DECK_SIZE-card register deck, runs one Fisher-Yates
//  swap per cycle from the free-running prng byte, then deals NUM_PLAYERS*HAND_SIZE cards
//  round-robin over a valid/ready stream. Sits between prng and the game/display logic and
//  replaces the single-cycle combinational shuffle loop.
// PARAMETERS
//  DECK_SIZE    52  cards in deck; card codes 0..DECK_SIZE-1
//  CARD_W        6  card code width, 2**CARD_W >= DECK_SIZE
//  RAND_W        8  width of rand_num
//  NUM_PLAYERS   4  hands dealt; NUM_PLAYERS*HAND_SIZE <= DECK_SIZE (elaboration error otherwise)
//  HAND_SIZE     7  cards per hand
// PORTS
//  clk          in   1                     single clock, rising edge
//  rst          in   1                     synchronous, active-high reset
//  start        in   1                     pulse: begin init+shuffle+deal
//  rand_num     in   RAND_W                prng output, new value every cycle
//  deal_ready   in   1                     consumer accepts deal_card this cycle
//  busy         out  1                     high in INIT/SHUFFLE/DEAL
//  deal_valid   out  1                     deal_card/deal_player valid
//  deal_card    out  CARD_W                card code
//  deal_player  out  $clog2(NUM_PLAYERS)   destination hand
//  deal_last    out  1                     qualifies final card of the deal
//  done         out  1                     level, high in DONE until next start or rst
// BEHAVIOUR
//  - Reset: state IDLE; busy, deal_valid, deal_card, deal_player, deal_last, done all 0; i, k, d = 0.
//    rst mid-operation aborts immediately; deck contents don't-care (INIT always rewrites).
//  - FSM IDLE -> INIT -> SHUFFLE -> DEAL -> DONE. start accepted only in IDLE or DONE; ignored
//    while busy. Accepting start clears done next cycle.
//  - INIT: DECK_SIZE cycles, deck[i] <= i, i = 0..DECK_SIZE-1.
//  - SHUFFLE: k from DECK_SIZE-1 down to 1; each accepted cycle j = rand_num % (k+1),
//    deck[k] <= deck[j], deck[j] <= deck[k]; j==k is a no-op. k==1 swap -> DEAL.
//  - DEAL: d = 0..N-1, N = NUM_PLAYERS*HAND_SIZE; deal_card = deck[d], deal_player = d % NUM_PLAYERS,
//    deal_last = (d==N-1). Outputs registered, held stable while deal_valid && !deal_ready;
//    transfer on valid&&ready, next card valid the following cycle (zero-bubble when ready high).
//    Last transfer -> DONE: deal_valid 0, done 1.
//  - Latency without rejection: start sampled at edge T -> INIT T+1..T+DECK_SIZE, SHUFFLE next
//    DECK_SIZE-1 cycles, first deal_valid at T+2*DECK_SIZE (T+104 default).
//  - Modulo: RAND_W-bit operand, k+1 <= DECK_SIZE; j width $clog2(DECK_SIZE).
// CONFIGURATION
//  UNBIASED_SHUFFLE_EN defined: rejection sampling; limit = 2**RAND_W - (2**RAND_W % (k+1));
//    rand_num >= limit -> no swap, k held, retry next cycle (busy stays 1).
//  Undefined: every SHUFFLE cycle swaps (plain modulo, slight bias); fixed latency above.
// STRUCTURE
//  Package deal_pkg: DECK_SIZE/CARD_W defaults, card_t typedef, state_t enum
//    {IDLE, INIT, SHUFFLE, DEAL, DONE}.
//  Sub-module rand_range_reduce: (rand_num, k) -> j, accept; holds the modulo and,
//    under UNBIASED_SHUFFLE_EN, the limit compare; accept tied 1 otherwise.
// TESTING
//  1 rand_num=0 constant, deal_ready=1, start -> 28 cards 1,2,...,28, players 0,1,2,3,0,...;
//    first valid at start+104; deal_last on card 28; done=1 next cycle.
//  2 Backpressure: deal_ready=0 for 10 cycles on card 5 -> deal_card/deal_player/deal_valid
//    stable; resumes with card 6 the cycle after ready returns.
//  3 start pulsed during SHUFFLE and DEAL -> ignored, sequence/timing identical to test 1.
//  4 rst asserted mid-SHUFFLE -> all outputs 0 next cycle; fresh start reproduces test 1 exactly.
//  5 UNBIASED_SHUFFLE_EN, rand_num=255 for 5 cycles at k=51 (limit 208) -> k holds 5 cycles,
//    first valid delayed 5 cycles; then rand_num=0 -> output as test 1.
//  6 Random rand_num stream, many runs -> each deal is 28 distinct codes < 52; the full deck
//    (scoreboard model) is a permutation of 0..51.

Source files
------------

// File: rtl/deal_pkg.sv
// rtl/deal_pkg.sv - shared defaults, card type and sequencer state encoding
// Purpose : common definitions imported by deal_sequencer and its bench.
// Contents: DECK_SIZE_DEF / CARD_W_DEF defaults, card_t, state_t {IDLE, INIT, SHUFFLE, DEAL, DONE}.
package deal_pkg;

    localparam int DECK_SIZE_DEF = 52;
    localparam int CARD_W_DEF    = 6;

    typedef logic [CARD_W_DEF-1:0] card_t;

    typedef enum logic [2:0] {
        IDLE,
        INIT,
        SHUFFLE,
        DEAL,
        DONE
    } state_t;

endpackage

// File: rtl/rand_range_reduce.sv
// rtl/rand_range_reduce.sv - maps a raw prng byte onto a swap index 0..k
// Purpose : j = rand_num % (k+1); accept qualifies the draw.
// Config  : UNBIASED_SHUFFLE_EN defined -> draws at or above the largest multiple of (k+1)
//           are rejected (accept = 0); undefined -> accept tied high.
// Ports   : i_rand_num [RAND_W] raw random value
//           i_k        [IDX_W]  current top-of-range index (range is 0..k)
//           o_j        [IDX_W]  reduced index
//           o_accept   [1]      draw usable this cycle
module rand_range_reduce #(
    parameter int RAND_W = 8,
    parameter int IDX_W  = 6
) (
    input  logic [RAND_W-1:0] i_rand_num,
    input  logic [IDX_W-1:0]  i_k,
    output logic [IDX_W-1:0]  o_j,
    output logic              o_accept
);

    // One extra bit so that both k+1 and 2**RAND_W are representable.
    localparam int OP_W = ((RAND_W > IDX_W) ? RAND_W : IDX_W) + 1;

    logic [OP_W-1:0] w_rand;
    logic [OP_W-1:0] w_div;
    logic [OP_W-1:0] w_rem;

    assign w_rand = OP_W'(i_rand_num);
    assign w_div  = OP_W'(i_k) + OP_W'(1);
    assign w_rem  = w_rand % w_div;
    assign o_j    = w_rem[IDX_W-1:0];

`ifdef UNBIASED_SHUFFLE_EN
    localparam logic [OP_W-1:0] RANGE = OP_W'(1) << RAND_W;

    logic [OP_W-1:0] w_limit;

    // Values at or above the largest multiple of (k+1) would favour low indices.
    assign w_limit  = RANGE - (RANGE % w_div);
    assign o_accept = (w_rand < w_limit);
`else
    assign o_accept = 1'b1;
`endif

endmodule

// File: rtl/deal_sequencer.sv
// rtl/deal_sequencer.sv - multi-cycle deck init, Fisher-Yates shuffle and round-robin deal
// Purpose : initialise deck[i]=i, one swap per cycle from the prng, then stream
//           NUM_PLAYERS*HAND_SIZE cards over a valid/ready interface.
// Config  : UNBIASED_SHUFFLE_EN enables rejection sampling in rand_range_reduce.
// Ports   : clk, rst (sync, active high), start (pulse, honoured in IDLE/DONE)
//           rand_num [RAND_W]  prng value, new every cycle
//           deal_ready         consumer accepts current card
//           busy               INIT/SHUFFLE/DEAL
//           deal_valid, deal_card [CARD_W], deal_player, deal_last  registered deal stream
//           done               level, high in DONE
module deal_sequencer
    import deal_pkg::*;
#(
    parameter int DECK_SIZE   = DECK_SIZE_DEF,
    parameter int CARD_W      = CARD_W_DEF,
    parameter int RAND_W      = 8,
    parameter int NUM_PLAYERS = 4,
    parameter int HAND_SIZE   = 7
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start,
    input  logic [RAND_W-1:0]              rand_num,
    input  logic                           deal_ready,
    output logic                           busy,
    output logic                           deal_valid,
    output logic [CARD_W-1:0]              deal_card,
    output logic [$clog2(NUM_PLAYERS)-1:0] deal_player,
    output logic                           deal_last,
    output logic                           done
);

    localparam int IDX_W = $clog2(DECK_SIZE);
    localparam int PL_W  = $clog2(NUM_PLAYERS);
    localparam int N     = NUM_PLAYERS * HAND_SIZE;

    if (N > DECK_SIZE) begin : g_bad_deal_size
        $error("deal_sequencer: NUM_PLAYERS*HAND_SIZE exceeds DECK_SIZE");
    end
    if ((2 ** CARD_W) < DECK_SIZE) begin : g_bad_card_w
        $error("deal_sequencer: CARD_W too narrow for DECK_SIZE");
    end

    state_t             r_state;
    state_t             w_next;
    logic [IDX_W-1:0]   r_i;
    logic [IDX_W-1:0]   r_k;
    logic [IDX_W-1:0]   r_d;
    logic [PL_W-1:0]    r_pnext;
    logic [CARD_W-1:0]  r_deck [DECK_SIZE];
    logic               r_valid;
    logic [CARD_W-1:0]  r_card;
    logic [PL_W-1:0]    r_player;
    logic               r_last;
    logic [IDX_W-1:0]   w_j;
    logic               w_accept;
    logic               w_xfer;
    logic               w_busy;
    logic               w_done;

    rand_range_reduce #(
        .RAND_W (RAND_W),
        .IDX_W  (IDX_W)
    ) u_reduce (
        .i_rand_num (rand_num),
        .i_k        (r_k),
        .o_j        (w_j),
        .o_accept   (w_accept)
    );

    assign w_xfer = r_valid && deal_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        w_busy = 1'b0;
        w_done = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) w_next = INIT;
            end
            INIT: begin
                w_busy = 1'b1;
                if (r_i == IDX_W'(DECK_SIZE - 1)) w_next = SHUFFLE;
            end
            SHUFFLE: begin
                w_busy = 1'b1;
                if (w_accept && (r_k == IDX_W'(1))) w_next = DEAL;
            end
            DEAL: begin
                w_busy = 1'b1;
                if (w_xfer && r_last) w_next = DONE;
            end
            DONE: begin
                w_done = 1'b1;
                if (start) w_next = INIT;
            end
            default: w_next = IDLE;
        endcase
    end

    // Counters and the registered deal stream.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_i      <= '0;
            r_k      <= '0;
            r_d      <= '0;
            r_pnext  <= '0;
            r_valid  <= 1'b0;
            r_card   <= '0;
            r_player <= '0;
            r_last   <= 1'b0;
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    if (start) r_i <= '0;
                end
                INIT: begin
                    r_i <= r_i + 1'b1;
                    if (r_i == IDX_W'(DECK_SIZE - 1)) r_k <= IDX_W'(DECK_SIZE - 1);
                end
                SHUFFLE: begin
                    if (w_accept) begin
                        r_k <= r_k - 1'b1;
                        if (r_k == IDX_W'(1)) begin
                            r_d     <= '0;
                            r_pnext <= '0;
                        end
                    end
                end
                DEAL: begin
                    // Load a new card when the output slot is empty or being drained.
                    if (!r_valid || deal_ready) begin
                        if (r_valid && r_last) begin
                            r_valid <= 1'b0;
                            r_last  <= 1'b0;
                        end else begin
                            r_valid  <= 1'b1;
                            r_card   <= r_deck[r_d];
                            r_player <= r_pnext;
                            r_last   <= (r_d == IDX_W'(N - 1));
                            r_d      <= r_d + 1'b1;
                            r_pnext  <= (r_pnext == PL_W'(NUM_PLAYERS - 1)) ? '0 : r_pnext + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Deck storage needs no reset: INIT rewrites every entry before use.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (r_state == INIT) begin
                r_deck[r_i] <= CARD_W'(r_i);
            end else if ((r_state == SHUFFLE) && w_accept) begin
                r_deck[r_k] <= r_deck[w_j];
                r_deck[w_j] <= r_deck[r_k];
            end
        end
    end

    assign busy        = w_busy;
    assign done        = w_done;
    assign deal_valid  = r_valid;
    assign deal_card   = r_card;
    assign deal_player = r_player;
    assign deal_last   = r_last;

endmodule
